// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - branch op, result and redirect channels of the branch resolve unit
interface branch_resolve_unit_if;
    logic        br_valid_i;
    logic        br_ready_o;
    logic [1:0]  br_kind_i;
    logic [2:0]  br_funct3_i;
    logic [31:0] br_pc_i;
    logic [31:0] br_rs1_i;
    logic [31:0] br_rs2_i;
    logic [31:0] br_imm_i;
    logic        br_pred_taken_i;
    logic [31:0] br_pred_target_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        res_taken_o;
    logic [31:0] res_target_o;
    logic [31:0] res_link_o;
    logic        res_illegal_o;
    logic        redirect_valid_o;
    logic        redirect_ready_i;
    logic [31:0] redirect_pc_o;

    modport slave (
        input  br_valid_i, br_kind_i, br_funct3_i, br_pc_i, br_rs1_i, br_rs2_i, br_imm_i,
               br_pred_taken_i, br_pred_target_i, res_ready_i, redirect_ready_i,
        output br_ready_o, res_valid_o, res_taken_o, res_target_o, res_link_o, res_illegal_o,
               redirect_valid_o, redirect_pc_o
    );

    modport master (
        output br_valid_i, br_kind_i, br_funct3_i, br_pc_i, br_rs1_i, br_rs2_i, br_imm_i,
               br_pred_taken_i, br_pred_target_i, res_ready_i, redirect_ready_i,
        input  br_ready_o, res_valid_o, res_taken_o, res_target_o, res_link_o, res_illegal_o,
               redirect_valid_o, redirect_pc_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch/jump resolver with fetch redirect and flush
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    branch_resolve_unit_if.slave bus,
    output logic                 flush_o,
    output logic [CNT_W-1:0]     cnt_br_o,
    output logic [CNT_W-1:0]     cnt_misp_o
);
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP, S_REDIR} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_kind;
    logic [2:0]  r_funct3;
    logic [31:0] r_pc, r_rs1, r_rs2, r_imm, r_pred_target;
    logic        r_pred_taken;
    logic        r_taken, r_illegal, r_misp;
    logic [31:0] r_target, r_link;
    logic [CNT_W-1:0] r_cnt_br, r_cnt_misp;

    logic        w_accept, w_res_fire, w_redir_fire;
    logic [2:0]  w_fn;
    logic        w_f3_ill, w_cmp;
    logic        w_taken, w_ill, w_misp;
    logic [31:0] w_seq_pc, w_tgt, w_next;

    // funct3 -> compare-block fn encoding
    always_comb begin
        w_fn     = 3'b000;
        w_f3_ill = 1'b0;
        case (r_funct3)
            3'b000:  w_fn = 3'b000;
            3'b001:  w_fn = 3'b001;
            3'b100:  w_fn = 3'b011;
            3'b101:  w_fn = 3'b010;
            3'b110:  w_fn = 3'b101;
            3'b111:  w_fn = 3'b110;
            default: w_f3_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_cmp = 1'b0;
        case (w_fn)
            3'b000:  w_cmp = (r_rs1 == r_rs2);
            3'b001:  w_cmp = (r_rs1 != r_rs2);
            3'b011:  w_cmp = ($signed(r_rs1) <  $signed(r_rs2));
            3'b010:  w_cmp = ($signed(r_rs1) >= $signed(r_rs2));
            3'b101:  w_cmp = (r_rs1 <  r_rs2);
            3'b110:  w_cmp = (r_rs1 >= r_rs2);
            default: w_cmp = 1'b0;
        endcase
    end

    always_comb begin
        w_seq_pc = r_pc + 32'd4;
        w_tgt    = r_pc + r_imm;
        w_taken  = 1'b0;
        w_ill    = 1'b0;
        case (r_kind)
            2'b00: begin
                w_taken = w_cmp & ~w_f3_ill;
                w_ill   = w_f3_ill;
            end
            2'b01: w_taken = 1'b1;
            2'b10: begin
                w_taken = 1'b1;
                w_tgt   = (r_rs1 + r_imm) & ~32'd1;
            end
            default: w_ill = 1'b1;
        endcase
        w_next = w_taken ? w_tgt : w_seq_pc;
        w_misp = ~w_ill & ((w_taken != r_pred_taken) | (w_taken & (r_pred_target != w_tgt)));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // flush_i overrides everything: no ready, no valids, no counting
    always_comb begin
        w_state_nxt          = r_state;
        w_accept             = 1'b0;
        w_res_fire           = 1'b0;
        w_redir_fire         = 1'b0;
        bus.br_ready_o       = 1'b0;
        bus.res_valid_o      = 1'b0;
        bus.redirect_valid_o = 1'b0;
        flush_o              = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    bus.br_ready_o = 1'b1;
                    if (bus.br_valid_i) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_EVAL;
                    end
                end
                S_EVAL: w_state_nxt = S_RESP;
                S_RESP: begin
                    bus.res_valid_o = 1'b1;
                    if (bus.res_ready_i) begin
                        w_res_fire  = 1'b1;
                        w_state_nxt = r_misp ? S_REDIR : S_IDLE;
                    end
                end
                S_REDIR: begin
                    bus.redirect_valid_o = 1'b1;
                    if (bus.redirect_ready_i) begin
                        w_redir_fire = 1'b1;
                        flush_o      = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_kind        <= 2'b00;
            r_funct3      <= 3'b000;
            r_pc          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_imm         <= '0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_taken       <= 1'b0;
            r_illegal     <= 1'b0;
            r_misp        <= 1'b0;
            r_target      <= '0;
            r_link        <= '0;
            r_cnt_br      <= '0;
            r_cnt_misp    <= '0;
        end else begin
            if (w_accept) begin
                r_kind        <= bus.br_kind_i;
                r_funct3      <= bus.br_funct3_i;
                r_pc          <= bus.br_pc_i;
                r_rs1         <= bus.br_rs1_i;
                r_rs2         <= bus.br_rs2_i;
                r_imm         <= bus.br_imm_i;
                r_pred_taken  <= bus.br_pred_taken_i;
                r_pred_target <= bus.br_pred_target_i;
            end
            if (r_state == S_EVAL && !flush_i) begin
                r_taken   <= w_taken;
                r_illegal <= w_ill;
                r_misp    <= w_misp;
                r_target  <= w_next;
                r_link    <= w_seq_pc;
            end
            if (w_res_fire)   r_cnt_br   <= r_cnt_br + 1'b1;
            if (w_redir_fire) r_cnt_misp <= r_cnt_misp + 1'b1;
        end
    end

    assign bus.res_taken_o   = r_taken;
    assign bus.res_target_o  = r_target;
    assign bus.res_link_o    = r_link;
    assign bus.res_illegal_o = r_illegal;
    assign bus.redirect_pc_o = r_target;
    assign cnt_br_o          = r_cnt_br;
    assign cnt_misp_o        = r_cnt_misp;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush_o;
    logic [CNT_W-1:0] cnt_br, cnt_misp;

    branch_resolve_unit_if bif();

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .flush_i    (flush),
        .bus        (bif.slave),
        .flush_o    (flush_o),
        .cnt_br_o   (cnt_br),
        .cnt_misp_o (cnt_misp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_br   = 0;
    int exp_misp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic void ref_model(
        input  logic [1:0]  kind, input logic [2:0] f3,
        input  logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
        input  logic        pt, input logic [31:0] ptgt,
        output logic        taken, output logic [31:0] nxt, output logic [31:0] link,
        output logic        ill, output logic misp);
        logic [31:0] tgt;
        taken = 1'b0;
        ill   = 1'b0;
        tgt   = pc + imm;
        case (kind)
            2'd0: case (f3)
                3'd0: taken = (rs1 == rs2);
                3'd1: taken = (rs1 != rs2);
                3'd4: taken = ($signed(rs1) <  $signed(rs2));
                3'd5: taken = ($signed(rs1) >= $signed(rs2));
                3'd6: taken = (rs1 <  rs2);
                3'd7: taken = (rs1 >= rs2);
                default: ill = 1'b1;
            endcase
            2'd1: taken = 1'b1;
            2'd2: begin taken = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
            default: ill = 1'b1;
        endcase
        link = pc + 32'd4;
        nxt  = taken ? tgt : link;
        misp = !ill && ((taken != pt) || (taken && ptgt != tgt));
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_cnts();
        check("cnt_br", 32'(cnt_br), 32'(exp_br & 15));
        check("cnt_misp", 32'(cnt_misp), 32'(exp_misp & 15));
    endtask

    // Presents one op at a negedge; returns at the negedge where the unit is in EVAL.
    task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
        step();
        check("ready_idle", 32'(bif.br_ready_o), 32'd1);
        bif.br_kind_i = kind; bif.br_funct3_i = f3; bif.br_pc_i = pc;
        bif.br_rs1_i = rs1; bif.br_rs2_i = rs2; bif.br_imm_i = imm;
        bif.br_pred_taken_i = pt; bif.br_pred_target_i = ptgt;
        bif.br_valid_i = 1'b1;
        step();
        bif.br_valid_i = 1'b0;
        bif.br_kind_i = 2'($urandom); bif.br_funct3_i = 3'($urandom); bif.br_pc_i = $urandom;
        bif.br_rs1_i = $urandom; bif.br_rs2_i = $urandom; bif.br_imm_i = $urandom;
        bif.br_pred_taken_i = 1'($urandom); bif.br_pred_target_i = $urandom;
        #1;
        check("ready_busy", 32'(bif.br_ready_o), 32'd0);
        check("res_early", 32'(bif.res_valid_o), 32'd0);
    endtask

    task automatic run_op(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                          input logic pt, input logic [31:0] ptgt, input int rd, input int dd);
        logic e_taken, e_ill, e_misp;
        logic [31:0] e_nxt, e_link;
        ref_model(kind, f3, pc, rs1, rs2, imm, pt, ptgt, e_taken, e_nxt, e_link, e_ill, e_misp);
        issue(kind, f3, pc, rs1, rs2, imm, pt, ptgt);
        step();
        check("res_valid", 32'(bif.res_valid_o), 32'd1);
        check("res_taken", 32'(bif.res_taken_o), 32'(e_taken));
        check("res_target", bif.res_target_o, e_nxt);
        check("res_link", bif.res_link_o, e_link);
        check("res_illegal", 32'(bif.res_illegal_o), 32'(e_ill));
        for (int i = 0; i < rd; i++) begin
            step();
            check("res_hold_valid", 32'(bif.res_valid_o), 32'd1);
            check("res_hold_target", bif.res_target_o, e_nxt);
            check("res_hold_ready", 32'(bif.br_ready_o), 32'd0);
        end
        bif.res_ready_i = 1'b1;
        #1;
        check("flush_on_res", 32'(flush_o), 32'd0);
        step();
        bif.res_ready_i = 1'b0;
        exp_br++;
        #1;
        check_cnts();
        check("res_drop", 32'(bif.res_valid_o), 32'd0);
        check("redir_valid", 32'(bif.redirect_valid_o), 32'(e_misp));
        if (e_misp) begin
            check("redir_pc", bif.redirect_pc_o, e_nxt);
            for (int i = 0; i < dd; i++) begin
                step();
                check("redir_hold_pc", bif.redirect_pc_o, e_nxt);
                check("redir_hold_ready", 32'(bif.br_ready_o), 32'd0);
                check("redir_hold_flush", 32'(flush_o), 32'd0);
            end
            bif.redirect_ready_i = 1'b1;
            #1;
            check("flush_pulse", 32'(flush_o), 32'd1);
            check("ready_in_redir", 32'(bif.br_ready_o), 32'd0);
            step();
            bif.redirect_ready_i = 1'b0;
            exp_misp++;
            #1;
            check("flush_end", 32'(flush_o), 32'd0);
            check("redir_drop", 32'(bif.redirect_valid_o), 32'd0);
            check_cnts();
        end
        check("ready_after", 32'(bif.br_ready_o), 32'd1);
    endtask

    initial begin
        logic [1:0]  k;
        logic [2:0]  f;
        logic [31:0] pc, a, b, imm, ptgt;
        logic        pt, t, il, m;
        logic [31:0] nx, lk;

        bif.br_valid_i = 1'b0; bif.br_kind_i = '0; bif.br_funct3_i = '0; bif.br_pc_i = '0;
        bif.br_rs1_i = '0; bif.br_rs2_i = '0; bif.br_imm_i = '0;
        bif.br_pred_taken_i = 1'b0; bif.br_pred_target_i = '0;
        bif.res_ready_i = 1'b0; bif.redirect_ready_i = 1'b0;

        #12;
        check("rst_ready", 32'(bif.br_ready_o), 32'd1);
        check("rst_res_valid", 32'(bif.res_valid_o), 32'd0);
        check("rst_redir_valid", 32'(bif.redirect_valid_o), 32'd0);
        check("rst_redir_pc", bif.redirect_pc_o, 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check_cnts();
        step();
        rst_n = 1'b1;

        run_op(2'd0, 3'd0, 32'h8000_0000, 32'd5, 32'd5, 32'h10, 1'b1, 32'h8000_0010, 0, 0);
        run_op(2'd0, 3'd4, 32'h8000_0100, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 0, 0);
        run_op(2'd0, 3'd6, 32'h8000_0100, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 0, 0);
        run_op(2'd2, 3'd0, 32'h8000_0200, 32'h8000_0103, 32'd0, 32'd0, 1'b1, 32'h8000_0100, 0, 1);
        run_op(2'd0, 3'd4, 32'h0000_1000, 32'h8000_0000, 32'd0, 32'hFFFF_FFF0, 1'b0, 32'h0, 5, 3);
        run_op(2'd0, 3'd2, 32'h0000_2000, 32'd1, 32'd1, 32'd8, 1'b1, 32'h0000_2008, 0, 0);
        run_op(2'd3, 3'd0, 32'h0000_3000, 32'd1, 32'd1, 32'd8, 1'b1, 32'h0, 0, 0);
        run_op(2'd1, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 1'b1, 32'h0000_0004, 1, 0);

        // flush_i during EVAL of a mispredicting op
        issue(2'd0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        check("flush_eval_flusho", 32'(flush_o), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush_eval_resv", 32'(bif.res_valid_o), 32'd0);
        check("flush_eval_ready", 32'(bif.br_ready_o), 32'd1);
        step();
        check("flush_eval_idle", 32'(bif.res_valid_o), 32'd0);
        check_cnts();

        // flush_i blocks acceptance in IDLE
        bif.br_valid_i = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_idle_ready", 32'(bif.br_ready_o), 32'd0);
        step();
        bif.br_valid_i = 1'b0;
        flush = 1'b0;
        step();
        step();
        check("flush_idle_noop", 32'(bif.res_valid_o), 32'd0);

        // flush_i while waiting in REDIR suppresses flush_o and the count
        issue(2'd1, 3'd0, 32'h100, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0);
        step();
        bif.res_ready_i = 1'b1;
        step();
        bif.res_ready_i = 1'b0;
        exp_br++;
        bif.redirect_ready_i = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_redir_flusho", 32'(flush_o), 32'd0);
        check("flush_redir_valid", 32'(bif.redirect_valid_o), 32'd0);
        step();
        flush = 1'b0;
        bif.redirect_ready_i = 1'b0;
        #1;
        check_cnts();
        check("flush_redir_idle", 32'(bif.br_ready_o), 32'd1);

        // counter wrap with CNT_W=4
        for (int i = 0; i < 16; i++)
            run_op(2'd1, 3'd0, 32'h400 + 32'(i * 4), 32'd0, 32'd0, 32'h8, 1'b1, 32'h408 + 32'(i * 4), 0, 0);

        for (int n = 0; n < 150; n++) begin
            k   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            f   = (k == 2'd0) ? 3'($urandom) : 3'd0;
            pc  = $urandom & 32'hFFFF_FFFC;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            ref_model(k, f, pc, a, b, imm, 1'b0, 32'h0, t, nx, lk, il, m);
            if ($urandom_range(0, 1) == 0) begin
                pt = t;
                ptgt = t ? nx : $urandom;
            end else begin
                pt = 1'($urandom);
                ptgt = $urandom;
            end
            run_op(k, f, pc, a, b, imm, pt, ptgt, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // asynchronous reset while in REDIR
        issue(2'd0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0);
        step();
        bif.res_ready_i = 1'b1;
        step();
        bif.res_ready_i = 1'b0;
        exp_br++;
        #1;
        check("pre_rst_redir", 32'(bif.redirect_valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_br = 0;
        exp_misp = 0;
        check("arst_redir_valid", 32'(bif.redirect_valid_o), 32'd0);
        check("arst_ready", 32'(bif.br_ready_o), 32'd1);
        check("arst_redir_pc", bif.redirect_pc_o, 32'd0);
        check_cnts();
        step();
        rst_n = 1'b1;
        run_op(2'd0, 3'd1, 32'h10, 32'd1, 32'd2, 32'h8, 1'b1, 32'h18, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage sequencer for conditional branches and jumps in the NPC core.
- Accepts one branch op from decode over a valid/ready handshake and drives the existing compare block through an internal funct3-to-fn translation.
- Computes the target and link address, returns the result to writeback, and issues a fetch redirect plus a pipeline flush pulse on mispredict.
- Keeps wrap-around counters of resolved branches and mispredicts.

Parameters:
CNT_W, 32, width of the performance counters

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n_i  input  1  asynchronous active-low reset
flush_i  input  1  higher-priority pipeline kill (trap/exception)
br_valid_i  input  1  branch op valid
br_ready_o  output  1  unit can accept an op
br_kind_i  input  2  00 cond branch, 01 jal, 10 jalr, 11 reserved
br_funct3_i  input  3  branch condition (RISC-V funct3)
br_pc_i  input  32  pc of the op
br_rs1_i  input  32  source operand 1
br_rs2_i  input  32  source operand 2
br_imm_i  input  32  sign-extended offset
br_pred_taken_i  input  1  fetch prediction: taken
br_pred_target_i  input  32  fetch predicted target
res_valid_o  output  1  result valid
res_ready_i  input  1  writeback accepts result
res_taken_o  output  1  resolved direction
res_target_o  output  32  resolved next pc
res_link_o  output  32  pc+4, for rd
res_illegal_o  output  1  reserved kind or funct3
redirect_valid_o  output  1  fetch redirect request
redirect_ready_i  input  1  fetch accepts redirect
redirect_pc_o  output  32  correct next pc
flush_o  output  1  one-cycle younger-op kill
cnt_br_o  output  CNT_W  resolved-op count
cnt_misp_o  output  CNT_W  mispredict count

Behaviour:
- Reset values:
  - state IDLE.
  - All valid outputs, flush_o, res_* and counters 0.
  - redirect_pc_o 0.
  - br_ready_o 1.
- States:
  - IDLE: br_ready_o=1. On br_valid_i&br_ready_o, register all br_* inputs and go to EVAL.
  - EVAL: one cycle. Compare the registered operands. Register taken, target, link, illegal and misp. Go to RESP.
  - RESP: res_valid_o=1, outputs stable. On res_ready_i, increment cnt_br_o. Then go to REDIR if misp, else IDLE.
  - REDIR: redirect_valid_o=1 with redirect_pc_o stable. On redirect_ready_i, pulse flush_o in the same cycle, increment cnt_misp_o, and go to IDLE.
- Latency and throughput:
  - Accept in cycle 0, EVAL in cycle 1, res_valid_o high from cycle 2.
  - br_ready_o is high only in IDLE, so the unit has at most one op in flight and a minimum 3-cycle issue interval.
- Compare fn translation from funct3:
  - 000→000 (eq)
  - 001→001 (ne)
  - 100→011 (signed lt)
  - 101→010 (signed ge)
  - 110→101 (unsigned lt)
  - 111→110 (unsigned ge)
  - 010/011 are illegal: taken forced 0, fn don't-care.
- Resolution:
  - cond: taken=compare output; target=pc+imm.
  - jal: taken=1, target=pc+imm.
  - jalr: taken=1, target=(rs1+imm)&~1.
  - kind 11: illegal, taken=0.
  - link=pc+4 for all kinds.
  - All adds are 32-bit modulo 2^32; wrap is silent.
  - res_target_o = taken ? target : pc+4.
- Mispredict:
  - misp = !illegal & ((taken != pred_taken) | (taken & pred_target != target)).
  - redirect_pc_o = res_target_o.
  - Illegal ops never redirect; the trap path handles them.
- flush_i:
  - Highest priority in every state.
  - Next state IDLE; valids, flush_o and counter increments are suppressed that cycle.
  - An op presented with br_valid_i in the same cycle is not accepted, because br_ready_o is forced 0 while flush_i=1.
  - An in-flight op is dropped silently.
- Counters: increment only on handshake completion, wrap modulo 2^CNT_W, no saturation.
- Stability: res_* and redirect_pc_o are held while valid and not ready. Input changes after acceptance have no effect.
- Mid-operation reset (async): immediately restores all reset values, counters included.

Test Plan:
1. BEQ, rs1=rs2=5, pc=0x8000_0000, imm=0x10, pred_taken=1, pred_target=0x8000_0010 → res_taken=1, target=0x8000_0010, link=0x8000_0004; no redirect; cnt_br=1.
2. BLT, rs1=0xFFFF_FFFF, rs2=1, pred_taken=0 → taken=1 (signed); REDIR with redirect_pc=pc+imm; flush_o pulses exactly one cycle on the redirect_ready_i handshake; cnt_misp=1. Repeat as BLTU → taken=0, no redirect.
3. jalr, rs1=0x8000_0103, imm=0, pred_taken=1, pred_target=0x8000_0100 → target 0x8000_0102, mispredict, redirect to 0x8000_0102.
4. res_ready_i held low 5 cycles, then redirect_ready_i held low 3 cycles → outputs stable throughout; br_ready_o=0 until the cycle after the redirect handshake.
5. funct3=010 cond → res_illegal_o=1, taken=0, no redirect; flush_i asserted in EVAL on a mispredicting op → next state IDLE, no res_valid_o, no flush_o, counters unchanged.
6. CNT_W=4, 16 resolved ops → cnt_br_o wraps to 0. Pull rst_n_i low during REDIR → redirect_valid_o drops asynchronously, counters 0, br_ready_o=1.
